// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_ADDR_WIDTH = 3;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Parametrised single-clock FIFO with occupancy, threshold flags, sticky
// error flags, synchronous flush and standard or first-word-fall-through reads.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int FWFT       = MODE_STD,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int PTR_W = ADDR_WIDTH + 1;

    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $fatal(1, "fifo_sync_flags: ADDR_WIDTH must be at least 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $fatal(1, "fifo_sync_flags: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
        $fatal(1, "fifo_sync_flags: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
        $fatal(1, "fifo_sync_flags: FWFT must be MODE_STD or MODE_FWFT");
    end

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_THR  = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THR  = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered pointers; the extra MSB
    // distinguishes a full wrap from an empty FIFO.
    assign empty        = (wptr == rptr);
    assign full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                          (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign level        = wptr - rptr;
    assign almost_full  = (level >= AF_THR);
    assign almost_empty = (level <= AE_THR);

    // Full/empty are judged on the pre-edge state, so a same-cycle read never
    // frees a slot for the write.
    assign wr_acc = wr_en && !full  && !clr;
    assign rd_acc = rd_en && !empty && !clr;

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign rd_data = empty ? '0 : head;
    end else begin : g_std
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data <= '0;
            end else if (clr) begin
                rd_data <= '0;
            end else if (rd_acc) begin
                rd_data <= head;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: one standard-read and one FWFT instance, each
// checked against a queue-based reference model.
module tb_fifo_sync_flags;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // standard-read instance
    logic          clr_s = 1'b0, wr_s = 1'b0, rd_s = 1'b0;
    logic [DW-1:0] wd_s  = '0;
    logic [DW-1:0] rdd_s;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic [AW:0]   level_s;

    // FWFT instance
    logic          clr_f = 1'b0, wr_f = 1'b0, rd_f = 1'b0;
    logic [DW-1:0] wd_f  = '0;
    logic [DW-1:0] rdd_f;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [AW:0]   level_f;

    fifo_sync_flags #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (0), .AF_LEVEL (AF), .AE_LEVEL (AE)
    ) u_std (
        .clk (clk), .rst_n (rst_n), .clr (clr_s), .wr_en (wr_s), .wr_data (wd_s),
        .rd_en (rd_s), .rd_data (rdd_s), .full (full_s), .empty (empty_s),
        .almost_full (af_s), .almost_empty (ae_s), .level (level_s),
        .overflow (ovf_s), .underflow (unf_s)
    );

    fifo_sync_flags #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (1), .AF_LEVEL (AF), .AE_LEVEL (AE)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .clr (clr_f), .wr_en (wr_f), .wr_data (wd_f),
        .rd_en (rd_f), .rd_data (rdd_f), .full (full_f), .empty (empty_f),
        .almost_full (af_f), .almost_empty (ae_f), .level (level_f),
        .overflow (ovf_f), .underflow (unf_f)
    );

    // observed vectors: {full, empty, af, ae, ovf, unf, level, rd_data}
    wire [13:0] obs_s = {full_s, empty_s, af_s, ae_s, ovf_s, unf_s, level_s, rdd_s};
    wire [13:0] obs_f = {full_f, empty_f, af_f, ae_f, ovf_f, unf_f, level_f, rdd_f};

    localparam logic [13:0] RESET_VEC = 14'b0_1_0_1_0_0_0000_0000;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    logic [DW-1:0] qs[$];
    logic [DW-1:0] qf[$];
    logic          m_ovs = 1'b0, m_uns = 1'b0;
    logic          m_ovf = 1'b0, m_unf = 1'b0;
    logic [DW-1:0] m_rds = '0;

    function automatic logic [13:0] exp_s();
        int n = qs.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovs, m_uns, 4'(n), m_rds};
    endfunction

    function automatic logic [13:0] exp_f();
        int n = qf.size();
        logic [DW-1:0] head = (n > 0) ? qf[0] : '0;
        return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf, 4'(n), head};
    endfunction

    task automatic cyc_s(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        wr_s = w; wd_s = d; rd_s = r; clr_s = c;
        @(posedge clk);
        was_full  = (qs.size() == DEPTH);
        was_empty = (qs.size() == 0);
        if (c) begin
            qs.delete(); m_ovs = 1'b0; m_uns = 1'b0; m_rds = '0;
        end else begin
            if (r) begin
                if (was_empty) m_uns = 1'b1;
                else           m_rds = qs.pop_front();
            end
            if (w) begin
                if (was_full) m_ovs = 1'b1;
                else          qs.push_back(d);
            end
        end
        #1;
        wr_s = 1'b0; rd_s = 1'b0; clr_s = 1'b0;
    endtask

    task automatic cyc_f(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        wr_f = w; wd_f = d; rd_f = r; clr_f = c;
        @(posedge clk);
        was_full  = (qf.size() == DEPTH);
        was_empty = (qf.size() == 0);
        if (c) begin
            qf.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (r) begin
                if (was_empty) m_unf = 1'b1;
                else           void'(qf.pop_front());
            end
            if (w) begin
                if (was_full) m_ovf = 1'b1;
                else          qf.push_back(d);
            end
        end
        #1;
        wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0;
    endtask

    task automatic test_reset();
        cyc_s(1'b1, 4'h5, 1'b0, 1'b0);
        cyc_s(1'b1, 4'h6, 1'b0, 1'b0);
        cyc_s(1'b1, 4'h7, 1'b1, 1'b0);
        cyc_f(1'b1, 4'h9, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_s !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_async_std: got %b want %b", obs_s, RESET_VEC);
        end
        vectors++;
        if (obs_f !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_async_fwft: got %b want %b", obs_f, RESET_VEC);
        end
        @(negedge clk) rst_n = 1'b1;
        qs.delete(); qf.delete();
        m_ovs = 1'b0; m_uns = 1'b0; m_rds = '0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (obs_s !== RESET_VEC || obs_f !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_release: std %b fwft %b want %b", obs_s, obs_f, RESET_VEC);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cyc_s(1'b1, 4'(i), 1'b0, 1'b0);
            vectors++;
            if (obs_s !== exp_s() || level_s !== 4'(i)) begin
                miscompares++;
                $display("FAIL fill_step%0d: got %b want %b", i, obs_s, exp_s());
            end
        end
        cyc_s(1'b1, 4'hF, 1'b0, 1'b0);
        vectors++;
        if (ovf_s !== 1'b1 || level_s !== 4'd8 || full_s !== 1'b1 || obs_s !== exp_s()) begin
            miscompares++;
            $display("FAIL fill_overflow: got %b want %b", obs_s, exp_s());
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cyc_s(1'b0, '0, 1'b1, 1'b0);
            vectors++;
            if (rdd_s !== 4'(i + 1) || obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL drain_read%0d: got %b want %b", i, obs_s, exp_s());
            end
        end
        vectors++;
        if (empty_s !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_empty: got %b want 1", empty_s);
        end
        cyc_s(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (unf_s !== 1'b1 || rdd_s !== 4'h8 || obs_s !== exp_s()) begin
            miscompares++;
            $display("FAIL drain_underflow: got %b want %b", obs_s, exp_s());
        end
    endtask

    task automatic test_concurrent_wrap();
        for (int k = 0; k < 3; k++) cyc_s(1'b1, 4'(k + 3), 1'b0, 1'b0);
        for (int k = 3; k < 23; k++) begin
            cyc_s(1'b1, 4'(k + 3), 1'b1, 1'b0);
            vectors++;
            if (level_s !== 4'd3 || full_s !== 1'b0 || rdd_s !== 4'(k) ||
                obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL concurrent_cycle%0d: got %b want %b", k, obs_s, exp_s());
            end
        end
    endtask

    task automatic test_fwft();
        cyc_f(1'b1, 4'hA, 1'b0, 1'b0);
        vectors++;
        if (empty_f !== 1'b0 || rdd_f !== 4'hA || obs_f !== exp_f()) begin
            miscompares++;
            $display("FAIL fwft_first_word: got %b want %b", obs_f, exp_f());
        end
        cyc_f(1'b1, 4'hB, 1'b0, 1'b0);
        vectors++;
        if (rdd_f !== 4'hA || obs_f !== exp_f()) begin
            miscompares++;
            $display("FAIL fwft_hold_head: got %b want %b", obs_f, exp_f());
        end
        cyc_f(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (rdd_f !== 4'hB || obs_f !== exp_f()) begin
            miscompares++;
            $display("FAIL fwft_pop: got %b want %b", obs_f, exp_f());
        end
        cyc_f(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (empty_f !== 1'b1 || rdd_f !== 4'h0 || obs_f !== exp_f()) begin
            miscompares++;
            $display("FAIL fwft_drained: got %b want %b", obs_f, exp_f());
        end
    endtask

    task automatic test_clr();
        cyc_s(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc_s(1'b1, 4'(i + 1), 1'b0, 1'b0);
        cyc_s(1'b1, 4'hE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc_s(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (level_s !== 4'd5 || ovf_s !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_setup: level %0d ovf %b want 5 1", level_s, ovf_s);
        end
        cyc_s(1'b1, 4'hC, 1'b1, 1'b1);
        vectors++;
        if (level_s !== 4'd0 || empty_s !== 1'b1 || ovf_s !== 1'b0 || unf_s !== 1'b0 ||
            rdd_s !== 4'h0 || obs_s !== exp_s()) begin
            miscompares++;
            $display("FAIL clr_flush: got %b want %b", obs_s, exp_s());
        end
        cyc_s(1'b1, 4'h3, 1'b0, 1'b0);
        cyc_s(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (rdd_s !== 4'h3 || obs_s !== exp_s()) begin
            miscompares++;
            $display("FAIL clr_restart: got %b want %b", obs_s, exp_s());
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        for (int n = 0; n < 400; n++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 31) == 0);
            cyc_s(w, 4'($urandom), r, c);
            vectors++;
            if (obs_s !== exp_s()) begin
                miscompares++;
                $display("FAIL random_std_%0d: got %b want %b", n, obs_s, exp_s());
            end
        end
        for (int n = 0; n < 400; n++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 31) == 0);
            cyc_f(w, 4'($urandom), r, c);
            vectors++;
            if (obs_f !== exp_f()) begin
                miscompares++;
                $display("FAIL random_fwft_%0d: got %b want %b", n, obs_f, exp_f());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_drain();
        test_concurrent_wrap();
        test_fwft();
        test_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's 4-bit × 8-entry TinyTapeout FIFO.
- New over the previous generation:
  - configurable width and depth
  - standard or first-word-fall-through (FWFT) read mode
  - occupancy count and almost-full / almost-empty thresholds
  - sticky overflow / underflow error flags
  - synchronous flush
- Sits between ui_in/uo_out pin logic and the design datapath as the general buffering primitive.

Parameters:
- DATA_WIDTH, 4, data bits per entry.
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH entries.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_LEVEL, 6, almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous flush, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (FWFT: acknowledge of the head entry).
- rd_data  out  DATA_WIDTH  read data.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pointers = 0, level = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0.
  - The storage array is not reset.
- Pointers:
  - wptr and rptr are binary, ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits address storage.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - level = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
- Flag timing: all flags and level are combinational from registered pointers, so they reflect an accepted operation in the cycle after it.
- Write:
  - Accepted iff wr_en && !full && !clr.
  - On accept: mem[wptr] <= wr_data, wptr increments.
  - wr_en while full: data dropped, overflow <= 1.
  - A read in the same cycle does not free a slot for that cycle's write.
- Read:
  - Accepted iff rd_en && !empty && !clr; rptr increments.
  - rd_en while empty: underflow <= 1, pointers unchanged, rd_data unchanged.
- FWFT = 0:
  - rd_data is registered and loads mem[rptr] on an accepted read, i.e. valid one cycle after rd_en.
  - Otherwise rd_data holds its last value.
- FWFT = 1:
  - rd_data = mem[rptr] when !empty, else 0, combinationally from registered state.
  - A write into an empty FIFO becomes visible on rd_data the cycle after the write.
  - An accepted rd_en pops the head; the next entry appears the following cycle.
- Simultaneous wr and rd with 0 < level < DEPTH: both are accepted, level is unchanged, and order is preserved.
- Wrap-around: the pointers wrap naturally; data order must hold across any number of wraps.
- clr:
  - Priority over wr and rd in the same cycle; both are dropped and set no error flag.
  - Next cycle: pointers = 0, overflow = 0, underflow = 0, rd_data = 0.
- Elaboration: out-of-range AF_LEVEL or AE_LEVEL, or ADDR_WIDTH < 1, is a fatal elaboration error.

Decomposition:
- Package fifo_pkg: default DATA_WIDTH/ADDR_WIDTH constants, a depth function, and the FWFT mode constants (MODE_STD = 0, MODE_FWFT = 1).
- Sub-module fifo_regfile:
  - DEPTH × DATA_WIDTH array, one synchronous write port, one asynchronous read port, no reset.
  - fifo_sync_flags owns pointers, flags, the error logic and the output register.

Test Plan:
1. Reset / idle: assert rst_n low mid-traffic, then release -> level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0.
2. Fill (FWFT = 0): write 0x1..0x8 on consecutive cycles.
   - level steps 1..8.
   - almost_empty deasserts when level reaches 2; almost_full asserts at level 6; full at level 8.
   - A 9th write of 0xF -> dropped, overflow = 1, level stays 8.
3. Drain (FWFT = 0): 8 consecutive reads.
   - rd_data = 0x1..0x8, each one cycle after its rd_en; empty = 1 after the last.
   - An extra read -> underflow = 1, rd_data holds 0x8.
4. Concurrent and wrap: preload 3 entries, then 20 cycles of wr_en && rd_en with an incrementing pattern -> level stays 3, output order is exact across the pointer wrap, full never asserts.
5. FWFT = 1:
   - Write 0xA to an empty FIFO -> next cycle empty = 0 and rd_data = 0xA with no rd_en.
   - Write 0xB, then rd_en -> the following cycle rd_data = 0xB.
   - Further rd_en until empty -> rd_data = 0.
6. clr mid-operation: at level 5 with overflow = 1, assert clr together with wr_en and rd_en -> next cycle level = 0, empty = 1, overflow = 0, underflow = 0, no data written.
